// File: rtl/dmem_port_arbiter.sv
// Two-master arbiter for the single data-memory port: a CPU data path and a DMA/debug master.
// Sticky grants bounded by a hold counter; reads return one cycle later, tagged to the issuer.
module dmem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic              iCpuClock,
  input  logic              iCpuResetN,
  input  logic              iCpuReq,
  input  logic              iCpuWe,
  input  logic [ADDR_W-1:0] iCpuAddr,
  input  logic [DATA_W-1:0] iCpuWdata,
  output logic              oCpuGnt,
  output logic [DATA_W-1:0] oCpuRdata,
  output logic              oCpuRvalid,
  input  logic              iDmaReq,
  input  logic              iDmaWe,
  input  logic [ADDR_W-1:0] iDmaAddr,
  input  logic [DATA_W-1:0] iDmaWdata,
  output logic              oDmaGnt,
  output logic [DATA_W-1:0] oDmaRdata,
  output logic              oDmaRvalid,
  output logic              oMemWe,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemWdata,
  input  logic [DATA_W-1:0] iMemRdata,
  output logic [1:0]        oOwner
);

  localparam int            HW       = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_DMA  = 2'b10
  } owner_t;

  owner_t        r_last_owner;
  owner_t        w_last_owner_nxt;
  owner_t        w_owner;
  logic [HW-1:0] r_hold_cnt;
  logic [HW-1:0] w_hold_cnt_nxt;
  logic          r_cpu_rvalid;
  logic          r_dma_rvalid;
  logic          w_both_req;

  assign w_both_req = iCpuReq && iDmaReq;

  // Grant decision. A zero hold count with DMA as last owner only occurs after reset
  // or an idle cycle, and then contention is resolved CPU-first.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_owner = OWN_NONE;
    if (!iCpuResetN) begin
      w_owner = OWN_NONE;
    end else if (w_both_req) begin
      if (r_last_owner == OWN_DMA && r_hold_cnt == '0)
        w_owner = OWN_CPU;
      else if (r_hold_cnt < HOLD_MAX)
        w_owner = r_last_owner;
      else
        w_owner = (r_last_owner == OWN_CPU) ? OWN_DMA : OWN_CPU;
    end else if (iCpuReq) begin
      w_owner = OWN_CPU;
    end else if (iDmaReq) begin
      w_owner = OWN_DMA;
    end
  end

  always_comb begin
    w_last_owner_nxt = r_last_owner;
    w_hold_cnt_nxt   = '0;
    if (w_owner != OWN_NONE) begin
      w_last_owner_nxt = w_owner;
      if (w_owner == r_last_owner && w_both_req)
        w_hold_cnt_nxt = (r_hold_cnt == HOLD_MAX) ? HOLD_MAX : r_hold_cnt + 1'b1;
      else
        w_hold_cnt_nxt = HW'(1);
    end
  end

  always_ff @(posedge iCpuClock or negedge iCpuResetN) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (!iCpuResetN) begin
      r_last_owner <= OWN_DMA;
      r_hold_cnt   <= '0;
      r_cpu_rvalid <= 1'b0;
      r_dma_rvalid <= 1'b0;
    end else begin
      r_last_owner <= w_last_owner_nxt;
      r_hold_cnt   <= w_hold_cnt_nxt;
      r_cpu_rvalid <= (w_owner == OWN_CPU) && !iCpuWe;
      r_dma_rvalid <= (w_owner == OWN_DMA) && !iDmaWe;
    end
  end

  always_comb begin
    oMemWe    = 1'b0;
    oMemAddr  = '0;
    oMemWdata = '0;
    unique case (w_owner)
      OWN_CPU: begin
        oMemWe    = iCpuWe;
        oMemAddr  = iCpuAddr;
        oMemWdata = iCpuWdata;
      end
      OWN_DMA: begin
        oMemWe    = iDmaWe;
        oMemAddr  = iDmaAddr;
        oMemWdata = iDmaWdata;
      end
      default: ;
    endcase
  end

  assign oCpuGnt    = (w_owner == OWN_CPU);
  assign oDmaGnt    = (w_owner == OWN_DMA);
  assign oOwner     = w_owner;
  assign oCpuRvalid = r_cpu_rvalid;
  assign oDmaRvalid = r_dma_rvalid;
  // Read data is broadcast; only the Rvalid flags say whose it is.
  assign oCpuRdata  = iMemRdata;
  assign oDmaRdata  = iMemRdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios then randomized traffic,
// compared against a rule-level arbitration/memory model kept in the bench.
module tb_dmem_port_arbiter;

  localparam int MAX_HOLD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iCpuReq, iCpuWe, iDmaReq, iDmaWe;
  logic [31:0] iCpuAddr, iCpuWdata, iDmaAddr, iDmaWdata;
  logic        oCpuGnt, oCpuRvalid, oDmaGnt, oDmaRvalid, oMemWe;
  logic [31:0] oCpuRdata, oDmaRdata, oMemAddr, oMemWdata;
  logic [31:0] iMemRdata = '0;
  logic [1:0]  oOwner;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: last owner (1 CPU, 2 DMA), current streak, pending read return.
  int          m_last;
  int          m_streak;
  logic        p_cpu_rv, p_dma_rv;
  logic [31:0] p_rdata;
  logic [31:0] exp_mem [16];

  logic [1:0]  seen_owner;
  logic [31:0] seen_cpu_rdata;
  logic        seen_cpu_rvalid, seen_dma_rvalid;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(MAX_HOLD)) dut (
    .iCpuClock (clk),       .iCpuResetN(rst_n),
    .iCpuReq   (iCpuReq),   .iCpuWe    (iCpuWe),    .iCpuAddr (iCpuAddr), .iCpuWdata(iCpuWdata),
    .oCpuGnt   (oCpuGnt),   .oCpuRdata (oCpuRdata), .oCpuRvalid(oCpuRvalid),
    .iDmaReq   (iDmaReq),   .iDmaWe    (iDmaWe),    .iDmaAddr (iDmaAddr), .iDmaWdata(iDmaWdata),
    .oDmaGnt   (oDmaGnt),   .oDmaRdata (oDmaRdata), .oDmaRvalid(oDmaRvalid),
    .oMemWe    (oMemWe),    .oMemAddr  (oMemAddr),  .oMemWdata(oMemWdata),
    .iMemRdata (iMemRdata), .oOwner    (oOwner)
  );

  function automatic logic [31:0] seed(int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0000_0111;
  endfunction

  // Memory fixture: 16 words, 1-cycle read latency; unwritten words return their seed.
  logic [31:0] mem [16];
  logic [15:0] wr_mask = '0;
  always @(posedge clk) begin
    iMemRdata <= wr_mask[oMemAddr[5:2]] ? mem[oMemAddr[5:2]] : seed(int'(oMemAddr[5:2]));
    if (oMemWe) begin
      mem[oMemAddr[5:2]]     <= oMemWdata;
      wr_mask[oMemAddr[5:2]] <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last   = 2;
    m_streak = 0;
    p_cpu_rv = 1'b0;
    p_dma_rv = 1'b0;
  endtask

  // Called at posedge+1; holds reset over one rising edge, checks quiescent outputs.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    iCpuReq = 1'b1; iCpuWe = 1'b1; iCpuAddr = 32'h3C; iCpuWdata = 32'h1111_2222;
    iDmaReq = 1'b1; iDmaWe = 1'b1; iDmaAddr = 32'h38; iDmaWdata = 32'h3333_4444;
    #1;
    check({tag, "/owner"},   64'(oOwner),     64'(0));
    check({tag, "/cpu_gnt"}, 64'(oCpuGnt),    64'(0));
    check({tag, "/dma_gnt"}, 64'(oDmaGnt),    64'(0));
    check({tag, "/mem_we"},  64'(oMemWe),     64'(0));
    check({tag, "/addr"},    64'(oMemAddr),   64'(0));
    check({tag, "/wdata"},   64'(oMemWdata),  64'(0));
    check({tag, "/cpu_rv"},  64'(oCpuRvalid), 64'(0));
    @(posedge clk); #1;
    check({tag, "/cpu_rv_edge"}, 64'(oCpuRvalid), 64'(0));
    check({tag, "/dma_rv_edge"}, 64'(oDmaRvalid), 64'(0));
    rst_n = 1'b1;
    iCpuReq = 1'b0; iCpuWe = 1'b0; iCpuAddr = '0; iCpuWdata = '0;
    iDmaReq = 1'b0; iDmaWe = 1'b0; iDmaAddr = '0; iDmaWdata = '0;
    model_reset();
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance model, return at posedge+1.
  task automatic cycle(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                       input string tag);
    int          g;
    logic        e_we;
    logic [31:0] e_addr, e_wdata;
    iCpuReq = cr; iCpuWe = cw; iCpuAddr = ca; iCpuWdata = cd;
    iDmaReq = dr; iDmaWe = dw; iDmaAddr = da; iDmaWdata = dd;
    if (cr && dr) begin
      if (m_last == 2 && m_streak == 0) g = 1;
      else if (m_streak < MAX_HOLD)     g = m_last;
      else                              g = 3 - m_last;
    end else if (cr) g = 1;
    else if (dr)     g = 2;
    else             g = 0;
    e_we    = (g == 1) ? cw : (g == 2) ? dw : 1'b0;
    e_addr  = (g == 1) ? ca : (g == 2) ? da : 32'h0;
    e_wdata = (g == 1) ? cd : (g == 2) ? dd : 32'h0;
    @(negedge clk);
    seen_owner      = oOwner;
    seen_cpu_rdata  = oCpuRdata;
    seen_cpu_rvalid = oCpuRvalid;
    seen_dma_rvalid = oDmaRvalid;
    check({tag, "/owner"},   64'(oOwner),     64'(g));
    check({tag, "/cpu_gnt"}, 64'(oCpuGnt),    64'(g == 1));
    check({tag, "/dma_gnt"}, 64'(oDmaGnt),    64'(g == 2));
    check({tag, "/mem_we"},  64'(oMemWe),     64'(e_we));
    check({tag, "/addr"},    64'(oMemAddr),   64'(e_addr));
    check({tag, "/wdata"},   64'(oMemWdata),  64'(e_wdata));
    check({tag, "/cpu_rv"},  64'(oCpuRvalid), 64'(p_cpu_rv));
    check({tag, "/dma_rv"},  64'(oDmaRvalid), 64'(p_dma_rv));
    if (p_cpu_rv) check({tag, "/cpu_rdata"}, 64'(oCpuRdata), 64'(p_rdata));
    if (p_dma_rv) check({tag, "/dma_rdata"}, 64'(oDmaRdata), 64'(p_rdata));
    p_cpu_rv = (g == 1) && !cw;
    p_dma_rv = (g == 2) && !dw;
    if (g != 0) begin
      if (e_we) exp_mem[e_addr[5:2]] = e_wdata;
      else      p_rdata = exp_mem[e_addr[5:2]];
      if (g == m_last && cr && dr) m_streak = (m_streak < MAX_HOLD) ? m_streak + 1 : MAX_HOLD;
      else                         m_streak = 1;
      m_last = g;
    end else begin
      m_streak = 0;
    end
    @(posedge clk); #1;
  endtask

  logic [1:0] pat [12];

  initial begin
    pat = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};
    for (int i = 0; i < 16; i++) exp_mem[i] = seed(i);
    rst_n = 1'b0;
    #1;
    do_reset("reset");

    // 1: lone CPU read of 0x10
    cycle(1, 0, 32'h10, 0, 0, 0, 0, 0, "t1_rd");
    cycle(0, 0, 0, 0, 0, 0, 0, 0, "t1_ret");
    check("t1_rvalid", 64'(seen_cpu_rvalid), 64'(1));
    check("t1_data",   64'(seen_cpu_rdata),  64'(seed(4)));

    // 2: continuous contention after reset
    do_reset("t2_reset");
    for (int i = 0; i < 12; i++) begin
      cycle(1, 0, 32'h4, 0, 1, 0, 32'h8, 0, "t2_both");
      check("t2_pattern", 64'(seen_owner), 64'(pat[i]));
    end

    // 3: DMA write, later CPU read-back
    cycle(0, 0, 0, 0, 1, 1, 32'h20, 32'hDEADBEEF, "t3_wr");
    cycle(0, 0, 0, 0, 0, 0, 0, 0, "t3_gap");
    cycle(1, 0, 32'h20, 0, 0, 0, 0, 0, "t3_rd");
    cycle(0, 0, 0, 0, 0, 0, 0, 0, "t3_ret");
    check("t3_data", 64'(seen_cpu_rdata), 64'(32'hDEADBEEF));

    // 4: alternating lone reads, returns must alternate without bubbles
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) cycle(1, 0, 32'h4, 0, 0, 0, 0, 0, "t4_cpu");
      else            cycle(0, 0, 0, 0, 1, 0, 32'h8, 0, "t4_dma");
      if (i > 0) check("t4_alt", 64'({seen_cpu_rvalid, seen_dma_rvalid}), 64'((i % 2 == 0) ? 2'b01 : 2'b10));
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 0, "t4_tail");

    // 5: reset lands on the edge that would return a granted read
    iCpuReq = 1'b1; iCpuWe = 1'b0; iCpuAddr = 32'h10; iCpuWdata = '0;
    iDmaReq = 1'b0; iDmaWe = 1'b0; iDmaAddr = '0;     iDmaWdata = '0;
    @(negedge clk);
    check("t5_gnt", 64'(oCpuGnt), 64'(1));
    do_reset("t5_reset");

    // 6: idle resets the streak; CPU remains sticky owner on the next contention
    cycle(1, 0, 32'h0C, 0, 0, 0, 0, 0, "t6_cpu");
    cycle(0, 0, 0, 0, 0, 0, 0, 0, "t6_idle");
    check("t6_idle_we", 64'(oMemWe), 64'(0));
    cycle(1, 0, 32'h0C, 0, 1, 0, 32'h14, 0, "t6_both");
    check("t6_sticky", 64'(seen_owner), 64'(2'b01));
    cycle(0, 0, 0, 0, 0, 0, 0, 0, "t6_tail");

    // Randomized traffic with one mid-run reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset("rnd_reset");
      cycle($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3, {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom,
            $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3, {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom,
            "rnd");
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 0, "rnd_tail");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
